// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the accumulator-processor control unit.
package mc_ctrl_pkg;

  localparam int OPC_W = 3;
  localparam int ST_W  = 3;

  localparam logic [OPC_W-1:0] OP_LDA = 3'b000;
  localparam logic [OPC_W-1:0] OP_STA = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b011;
  localparam logic [OPC_W-1:0] OP_INP = 3'b100;
  localparam logic [OPC_W-1:0] OP_OUT = 3'b101;
  localparam logic [OPC_W-1:0] OP_JMP = 3'b110;
  localparam logic [OPC_W-1:0] OP_JZ  = 3'b111;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_MEMWR  = 3'd3,
    S_INLD   = 3'd4,
    S_OUTLD  = 3'd5,
    S_JUMP   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [1:0] ASRC_MEM = 2'b00;
  localparam logic [1:0] ASRC_ALU = 2'b01;
  localparam logic [1:0] ASRC_IN  = 2'b10;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/flag in, strobes and selects out.
interface mc_control_unit_if;
  import mc_ctrl_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic             acc_zero;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             iord;
  logic             mem_wr;
  logic             aload;
  logic [1:0]       a_src;
  logic             alu_op;
  logic             out_load;
  logic             instr_done;
  logic [ST_W-1:0]  state;

  // Controller side
  modport master (
    input  opcode, acc_zero,
    output pc_write, pc_src, ir_write, iord, mem_wr, aload,
           a_src, alu_op, out_load, instr_done, state
  );

  // Datapath side
  modport slave (
    output opcode, acc_zero,
    input  pc_write, pc_src, ir_write, iord, mem_wr, aload,
           a_src, alu_op, out_load, instr_done, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state/opcode to strobe decoder. Strobes are gated off
// while reset is low so an aborted instruction leaves no partial write.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             acc_zero,
  input  logic             reset,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_wr,
  output logic             aload,
  output logic [1:0]       a_src,
  output logic             alu_op,
  output logic             out_load,
  output logic             instr_done
);

  logic pc_write_raw;
  logic ir_write_raw;
  logic mem_wr_raw;
  logic aload_raw;
  logic out_load_raw;
  logic instr_done_raw;

  // Moore decode; acc_zero only matters in DECODE for a not-taken JZ
  always_comb begin
    pc_write_raw   = 1'b0;
    pc_src         = 1'b0;
    ir_write_raw   = 1'b0;
    iord           = 1'b0;
    mem_wr_raw     = 1'b0;
    aload_raw      = 1'b0;
    a_src          = ASRC_MEM;
    alu_op         = 1'b0;
    out_load_raw   = 1'b0;
    instr_done_raw = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
      end
      S_DECODE: begin
        instr_done_raw = (opcode == OP_JZ) && !acc_zero;
      end
      S_MEMRD: begin
        iord           = 1'b1;
        aload_raw      = 1'b1;
        a_src          = (opcode == OP_LDA) ? ASRC_MEM : ASRC_ALU;
        alu_op         = opcode[0];
        instr_done_raw = 1'b1;
      end
      S_MEMWR: begin
        iord           = 1'b1;
        mem_wr_raw     = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_INLD: begin
        aload_raw      = 1'b1;
        a_src          = ASRC_IN;
        instr_done_raw = 1'b1;
      end
      S_OUTLD: begin
        out_load_raw   = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_JUMP: begin
        pc_write_raw   = 1'b1;
        pc_src         = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset overrides every strobe combinationally
  always_comb begin
    pc_write   = pc_write_raw   & reset;
    ir_write   = ir_write_raw   & reset;
    mem_wr     = mem_wr_raw     & reset;
    aload      = aload_raw      & reset;
    out_load   = out_load_raw   & reset;
    instr_done = instr_done_raw & reset;
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 8-bit accumulator processor.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mc_control_unit_if.master  bus
);

  state_t state_q;
  state_t state_d;

  // Next-state: opcode dispatch in DECODE, everything else returns to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: state_d = S_MEMRD;
          OP_STA:                 state_d = S_MEMWR;
          OP_INP:                 state_d = S_INLD;
          OP_OUT:                 state_d = S_OUTLD;
          OP_JMP:                 state_d = S_JUMP;
          default:                state_d = bus.acc_zero ? S_JUMP : S_FETCH;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mc_ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (bus.opcode),
    .acc_zero   (bus.acc_zero),
    .reset      (reset),
    .pc_write   (bus.pc_write),
    .pc_src     (bus.pc_src),
    .ir_write   (bus.ir_write),
    .iord       (bus.iord),
    .mem_wr     (bus.mem_wr),
    .aload      (bus.aload),
    .a_src      (bus.a_src),
    .alu_op     (bus.alu_op),
    .out_load   (bus.out_load),
    .instr_done (bus.instr_done)
  );

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed literal checks, then random
// instruction streams against an instruction-level model.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] st;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_wr;
    logic       aload;
    logic [1:0] a_src;
    logic       alu_op;
    logic       out_load;
    logic       instr_done;
    logic [2:0] op;
    logic       az;
  } rec_t;

  rec_t q[$];
  rec_t exp_r;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic rec_t blank(input logic [2:0] st, input logic [2:0] op, input logic az);
    rec_t r;
    r.st = st; r.pc_write = 0; r.pc_src = 0; r.ir_write = 0; r.iord = 0;
    r.mem_wr = 0; r.aload = 0; r.a_src = 2'b00; r.alu_op = 0; r.out_load = 0;
    r.instr_done = 0; r.op = op; r.az = az;
    return r;
  endfunction

  // Expand one instruction into the per-cycle outputs it must produce
  task automatic build_instr();
    logic [2:0] op;
    logic       az;
    rec_t       r;
    op = 3'($urandom_range(0, 7));
    az = 1'($urandom_range(0, 1));
    r = blank(3'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    r.ir_write = 1; r.pc_write = 1;
    q.push_back(r);
    r = blank(3'd1, op, az);
    r.instr_done = (op == 3'b111) && !az;
    q.push_back(r);
    if (!(op == 3'b111 && !az)) begin
      r = blank(3'd0, op, 1'($urandom_range(0, 1)));
      r.instr_done = 1;
      case (op)
        3'b000: begin r.st = 3'd2; r.iord = 1; r.aload = 1; r.a_src = 2'b00; end
        3'b001: begin r.st = 3'd3; r.iord = 1; r.mem_wr = 1; end
        3'b010: begin r.st = 3'd2; r.iord = 1; r.aload = 1; r.a_src = 2'b01; end
        3'b011: begin r.st = 3'd2; r.iord = 1; r.aload = 1; r.a_src = 2'b01; r.alu_op = 1; end
        3'b100: begin r.st = 3'd4; r.aload = 1; r.a_src = 2'b10; end
        3'b101: begin r.st = 3'd5; r.out_load = 1; end
        default: begin r.st = 3'd6; r.pc_write = 1; r.pc_src = 1; end
      endcase
      q.push_back(r);
    end
  endtask

  // Per-cycle compare against the model during the random phase
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",      8'(bus.state),      8'(exp_r.st));
      chk("pc_write",   8'(bus.pc_write),   8'(exp_r.pc_write));
      chk("pc_src",     8'(bus.pc_src),     8'(exp_r.pc_src));
      chk("ir_write",   8'(bus.ir_write),   8'(exp_r.ir_write));
      chk("iord",       8'(bus.iord),       8'(exp_r.iord));
      chk("mem_wr",     8'(bus.mem_wr),     8'(exp_r.mem_wr));
      chk("aload",      8'(bus.aload),      8'(exp_r.aload));
      chk("a_src",      8'(bus.a_src),      8'(exp_r.a_src));
      chk("alu_op",     8'(bus.alu_op),     8'(exp_r.alu_op));
      chk("out_load",   8'(bus.out_load),   8'(exp_r.out_load));
      chk("instr_done", 8'(bus.instr_done), 8'(exp_r.instr_done));
    end
  end

  task automatic drive(input logic r, input logic [2:0] op, input logic az);
    @(posedge clk);
    #1;
    reset = r; bus.opcode = op; bus.acc_zero = az;
    @(negedge clk);
  endtask

  initial begin
    rec_t h;
    logic rv;
    bus.opcode = 3'b001;
    bus.acc_zero = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mem_wr",   8'(bus.mem_wr),   8'd0);
    chk("rst_pc_write", 8'(bus.pc_write), 8'd0);
    chk("rst_ir_write", 8'(bus.ir_write), 8'd0);
    drive(0, 3'b001, 0);
    chk("rst_state",    8'(bus.state),    8'd0);
    chk("rst_mem_wr2",  8'(bus.mem_wr),   8'd0);
    chk("rst_ir_write2",8'(bus.ir_write), 8'd0);
    drive(1, 3'b001, 0);
    chk("fetch_ir_write", 8'(bus.ir_write), 8'd1);
    chk("fetch_pc_write", 8'(bus.pc_write), 8'd1);
    chk("fetch_iord",     8'(bus.iord),     8'd0);
    // ADD
    drive(1, 3'b010, 0);
    chk("add_decode_st", 8'(bus.state), 8'd1);
    chk("add_decode_done", 8'(bus.instr_done), 8'd0);
    drive(1, 3'b010, 0);
    chk("add_st",     8'(bus.state),      8'd2);
    chk("add_aload",  8'(bus.aload),      8'd1);
    chk("add_asrc",   8'(bus.a_src),      8'd1);
    chk("add_aluop",  8'(bus.alu_op),     8'd0);
    chk("add_iord",   8'(bus.iord),       8'd1);
    chk("add_done",   8'(bus.instr_done), 8'd1);
    drive(1, 3'b010, 0);
    chk("add_back_fetch", 8'(bus.state), 8'd0);
    // SUB
    drive(1, 3'b011, 0);
    drive(1, 3'b011, 0);
    chk("sub_st",    8'(bus.state),  8'd2);
    chk("sub_aluop", 8'(bus.alu_op), 8'd1);
    chk("sub_asrc",  8'(bus.a_src),  8'd1);
    drive(1, 3'b011, 0);
    // LDA
    drive(1, 3'b000, 0);
    drive(1, 3'b000, 0);
    chk("lda_st",   8'(bus.state), 8'd2);
    chk("lda_asrc", 8'(bus.a_src), 8'd0);
    drive(1, 3'b000, 0);
    // STA
    drive(1, 3'b001, 0);
    chk("sta_dec_mem_wr", 8'(bus.mem_wr), 8'd0);
    drive(1, 3'b001, 0);
    chk("sta_st",     8'(bus.state),  8'd3);
    chk("sta_mem_wr", 8'(bus.mem_wr), 8'd1);
    chk("sta_iord",   8'(bus.iord),   8'd1);
    drive(1, 3'b001, 0);
    chk("sta_after_mem_wr", 8'(bus.mem_wr), 8'd0);
    // OUT
    drive(1, 3'b101, 0);
    drive(1, 3'b101, 0);
    chk("out_st",   8'(bus.state),    8'd5);
    chk("out_load", 8'(bus.out_load), 8'd1);
    drive(1, 3'b101, 0);
    chk("out_load_after", 8'(bus.out_load), 8'd0);
    // JZ taken; acc_zero changes after DECODE must not matter
    drive(1, 3'b111, 1);
    drive(1, 3'b111, 0);
    chk("jz_t_st",     8'(bus.state),    8'd6);
    chk("jz_t_pcw",    8'(bus.pc_write), 8'd1);
    chk("jz_t_pcsrc",  8'(bus.pc_src),   8'd1);
    drive(1, 3'b111, 1);
    // JZ not taken: two cycles
    drive(1, 3'b111, 0);
    chk("jz_nt_st",   8'(bus.state),      8'd1);
    chk("jz_nt_done", 8'(bus.instr_done), 8'd1);
    drive(1, 3'b111, 1);
    chk("jz_nt_fetch", 8'(bus.state), 8'd0);
    // Mid-instruction reset in MEMWR
    drive(1, 3'b001, 0);
    drive(0, 3'b001, 0);
    chk("abort_st",     8'(bus.state),      8'd3);
    chk("abort_mem_wr", 8'(bus.mem_wr),     8'd0);
    chk("abort_done",   8'(bus.instr_done), 8'd0);
    drive(1, 3'b100, 0);
    chk("abort_refetch", 8'(bus.state),    8'd0);
    chk("abort_irw",     8'(bus.ir_write), 8'd1);
    // INP
    drive(1, 3'b100, 0);
    drive(1, 3'b100, 0);
    chk("inp_st",    8'(bus.state), 8'd4);
    chk("inp_aload", 8'(bus.aload), 8'd1);
    chk("inp_asrc",  8'(bus.a_src), 8'd2);

    // Random phase: DUT sits at the end of an instruction, next cycle is FETCH
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) build_instr();
      rv = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      h = q.pop_front();
      reset = rv;
      bus.opcode = h.op;
      bus.acc_zero = h.az;
      if (!rv) begin
        h.pc_write = 0; h.ir_write = 0; h.mem_wr = 0;
        h.aload = 0; h.out_load = 0; h.instr_done = 0;
        q.delete();
      end
      exp_r = h;
      chk_en = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control FSM for the 8-bit accumulator processor.
- Sequences fetch, decode, memory access, accumulator write-back and branch for every instruction.
- Drives the strobes and selects of the shared datapath: PC, IR, unified memory, accumulator and OUT register.
- Sits beside the datapath inside Complete_MIPS. The opcode comes from IR[7:5]; the operand address comes from the datapath.

Parameters:
- OPC_W, 3, opcode width (IR[7:5])
- ST_W, 3, state register width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- opcode  in  OPC_W  instruction opcode from the IR output
- acc_zero  in  1  high when the accumulator equals 8'd0
- pc_write  out  1  load the PC this cycle
- pc_src  out  1  0 = PC+1, 1 = IR jump target
- ir_write  out  1  capture memory data into the IR
- iord  out  1  memory address select: 0 = PC, 1 = IR operand address
- mem_wr  out  1  memory write strobe (accumulator to mem[IR addr])
- aload  out  1  load the accumulator
- a_src  out  2  accumulator source: 00 = mem data, 01 = ALU result, 10 = IN port
- alu_op  out  1  0 = ACC + mem, 1 = ACC - mem
- out_load  out  1  load the OUT register from the accumulator
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- state  out  ST_W  current state, for debug and testbench

Behaviour:
- Memory: combinational read, synchronous write. IR, PC and ACC load on the rising edge when strobed.
- Opcodes: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 INP, 101 OUT, 110 JMP, 111 JZ. All eight are defined; there is no illegal-opcode path.
- FSM is Moore. All outputs decode from the state only, except DECODE's use of acc_zero for JZ.
- Unlisted outputs are 0 in every state.
- States and transitions:
  - FETCH (0): iord=0, ir_write=1, pc_write=1, pc_src=0. Next state DECODE.
  - DECODE (1), dispatched on opcode:
    - LDA/ADD/SUB -> MEMRD
    - STA -> MEMWR
    - INP -> INLD
    - OUT -> OUTLD
    - JMP -> JUMP
    - JZ -> JUMP if acc_zero, else FETCH with instr_done=1
  - MEMRD (2): iord=1, aload=1. a_src=00 for LDA, 01 for ADD/SUB. alu_op=opcode[0]. instr_done=1. Next state FETCH.
  - MEMWR (3): iord=1, mem_wr=1, instr_done=1. Next state FETCH.
  - INLD (4): aload=1, a_src=10, instr_done=1. Next state FETCH.
  - OUTLD (5): out_load=1, instr_done=1. Next state FETCH.
  - JUMP (6): pc_write=1, pc_src=1, instr_done=1. Next state FETCH.
  - State 7 is unused and goes to FETCH with no strobes.
- Latency in cycles:
  - LDA/ADD/SUB/STA/INP/OUT/JMP: 3
  - JZ taken: 3
  - JZ not taken: 2
- Opcode is only sampled in DECODE and MEMRD. The IR is stable from the end of FETCH.
- Reset:
  - While reset==0, every strobe (pc_write, ir_write, mem_wr, aload, out_load, instr_done) is forced to 0 combinationally.
  - On the rising edge with reset==0, state becomes FETCH.
  - Reset asserted mid-instruction aborts the instruction: no partial write occurs in the reset cycle, and the first fetch follows the first edge with reset==1.
- acc_zero is sampled only in DECODE. Changes in other states are ignored.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams (OP_LDA..OP_JZ)
  - state encodings (S_FETCH..S_JUMP)
  - a_src encodings (ASRC_MEM, ASRC_ALU, ASRC_IN)
- Optional sub-module mc_ctrl_decode: purely combinational state/opcode-to-strobe decoder. It keeps the state register and next-state logic separate from the output decode.

Test Plan:
- Reset: hold reset=0 for 2 edges with opcode=001 -> mem_wr=0, pc_write=0, ir_write=0, and state=0 after the first edge. Release reset -> ir_write=1 and pc_write=1 in the next cycle.
- ADD: opcode=010 after FETCH -> state sequence 0,1,2. In state 2: aload=1, a_src=01, alu_op=0, iord=1, instr_done=1. Back to state 0 on the 4th edge.
- SUB and LDA: opcode=011 -> MEMRD with alu_op=1, a_src=01. Opcode=000 -> a_src=00.
- STA and OUT: opcode=001 -> mem_wr=1 for exactly 1 cycle in state 3 with iord=1. Opcode=101 -> out_load=1 for 1 cycle in state 5.
- JZ: opcode=111 with acc_zero=1 -> state 6, pc_write=1, pc_src=1. With acc_zero=0 -> state 0 after DECODE and instr_done=1 in DECODE; total 2 cycles.
- Mid-instruction reset: reset=0 while in MEMWR (state 3) -> mem_wr=0 in that cycle and state=0 on the next edge. Then run INP (100) -> aload=1, a_src=10 in state 4.
